// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral register map and the uart_host bus initiator.
package uart_pkg;

    typedef enum logic [1:0] {
        REG_BAUD   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_DATA   = 2'd3
    } reg_addr_e;

    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_RX_FULL   = 2;
    localparam int STAT_RX_EMPTY  = 3;
    localparam int STAT_FRAME_ERR = 4;

    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_IDLE,
        ST_POLL_REQ,
        ST_POLL_CAP,
        ST_TX_WR,
        ST_RX_REQ,
        ST_RX_CAP,
        ST_GAP
    } host_state_e;

endpackage

// File: rtl/uart_host_if.sv
// Register bus between uart_host (master) and the UART peripheral (slave).
interface uart_host_if;
    logic        stb_o;
    logic [1:0]  adr_o;
    logic [3:0]  byte_sel_o;
    logic        we_o;
    logic [31:0] data_o;
    logic [31:0] data_i;

    modport master (
        output stb_o, adr_o, byte_sel_o, we_o, data_o,
        input  data_i
    );

    modport slave (
        input  stb_o, adr_o, byte_sel_o, we_o, data_o,
        output data_i
    );
endinterface

// File: rtl/uart_host.sv
// Bus initiator that configures the UART once, then polls STATUS and shuttles
// bytes between the TX/RX streams and the peripheral DATA register.
module uart_host
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter logic [1:0] CTRL_INIT  = 2'b11,
    parameter int         POLL_GAP   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    uart_host_if.master           bus,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ready_i,
    output logic [4:0]            status_o
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    host_state_e state_reg, state_next;
    host_state_e exit_target, after_xfer;

    logic                  stb_reg, stb_next;
    logic                  we_reg, we_next;
    logic [1:0]            adr_reg, adr_next;
    logic [3:0]            bsel_reg, bsel_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  tx_ready_reg, tx_ready_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic [4:0]            status_reg, status_next;
    logic                  rr_tx_first_reg, rr_tx_first_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
    logic                  tx_elig, rx_elig;

    assign exit_target = en_i ? ST_POLL_REQ : ST_IDLE;
    assign after_xfer  = (POLL_GAP == 0) ? exit_target : ST_GAP;

    always_comb begin
        state_next       = state_reg;
        rr_tx_first_next = rr_tx_first_reg;
        gap_cnt_next     = '0;
        status_next      = status_reg;
        rx_data_next     = rx_data_reg;
        rx_valid_next    = rx_valid_reg & ~rx_ready_i;
        tx_elig          = 1'b0;
        rx_elig          = 1'b0;
        unique case (state_reg)
            // The CTRL write is on the bus only once stb_reg is set; until then stay to issue it.
            ST_CFG:      if (stb_reg) state_next = exit_target;
            ST_IDLE:     if (en_i) state_next = ST_POLL_REQ;
            ST_POLL_REQ: state_next = ST_POLL_CAP;
            ST_POLL_CAP: begin
                status_next = bus.data_i[4:0];
                tx_elig     = tx_valid_i & ~bus.data_i[STAT_TX_FULL];
                rx_elig     = ~bus.data_i[STAT_RX_EMPTY] & ~rx_valid_reg;
                if (tx_elig && (!rx_elig || rr_tx_first_reg)) begin
                    state_next       = ST_TX_WR;
                    rr_tx_first_next = 1'b0;
                end else if (rx_elig) begin
                    state_next       = ST_RX_REQ;
                    rr_tx_first_next = 1'b1;
                end else begin
                    state_next = after_xfer;
                end
            end
            ST_TX_WR:    state_next = after_xfer;
            ST_RX_REQ:   state_next = ST_RX_CAP;
            ST_RX_CAP: begin
                rx_data_next  = bus.data_i[DATA_WIDTH-1:0];
                rx_valid_next = 1'b1;
                state_next    = after_xfer;
            end
            ST_GAP: begin
                if (int'(gap_cnt_reg) + 1 >= POLL_GAP) state_next = exit_target;
                else gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
            default:     state_next = ST_CFG;
        endcase
    end

    // Bus outputs are decoded from the state being entered so they leave a register.
    always_comb begin
        stb_next      = 1'b0;
        we_next       = 1'b0;
        adr_next      = 2'd0;
        bsel_next     = 4'b0000;
        wdata_next    = '0;
        tx_ready_next = 1'b0;
        unique case (state_next)
            ST_CFG: begin
                stb_next   = 1'b1;
                we_next    = 1'b1;
                adr_next   = REG_CTRL;
                bsel_next  = 4'b0001;
                wdata_next = {30'b0, CTRL_INIT};
            end
            ST_POLL_REQ: begin
                stb_next = 1'b1;
                adr_next = REG_STATUS;
            end
            ST_TX_WR: begin
                stb_next      = 1'b1;
                we_next       = 1'b1;
                adr_next      = REG_DATA;
                bsel_next     = 4'b0001;
                wdata_next    = 32'(tx_data_i);
                tx_ready_next = 1'b1;
            end
            ST_RX_REQ: begin
                stb_next = 1'b1;
                adr_next = REG_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= ST_CFG;
            stb_reg         <= 1'b0;
            we_reg          <= 1'b0;
            adr_reg         <= 2'd0;
            bsel_reg        <= 4'b0000;
            wdata_reg       <= '0;
            tx_ready_reg    <= 1'b0;
            rx_valid_reg    <= 1'b0;
            rx_data_reg     <= '0;
            status_reg      <= '0;
            rr_tx_first_reg <= 1'b1;
            gap_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            stb_reg         <= stb_next;
            we_reg          <= we_next;
            adr_reg         <= adr_next;
            bsel_reg        <= bsel_next;
            wdata_reg       <= wdata_next;
            tx_ready_reg    <= tx_ready_next;
            rx_valid_reg    <= rx_valid_next;
            rx_data_reg     <= rx_data_next;
            status_reg      <= status_next;
            rr_tx_first_reg <= rr_tx_first_next;
            gap_cnt_reg     <= gap_cnt_next;
        end
    end

    assign bus.stb_o      = stb_reg;
    assign bus.we_o       = we_reg;
    assign bus.adr_o      = adr_reg;
    assign bus.byte_sel_o = bsel_reg;
    assign bus.data_o     = wdata_reg;
    assign tx_ready_o     = tx_ready_reg;
    assign rx_valid_o     = rx_valid_reg;
    assign rx_data_o      = rx_data_reg;
    assign status_o       = status_reg;

    generate
        if (DATA_WIDTH < 32) begin : g_rdata_tail
            logic unused_rdata;
            assign unused_rdata = ^bus.data_i[31:DATA_WIDTH];
        end
    endgenerate

endmodule

// File: doc/uart_host.md
# uart_host

Bus initiator that drives the memory-mapped UART peripheral's four-register interface (BAUD, CTRL, STATUS, DATA) on behalf of byte-stream clients. After reset it writes CTRL once to enable TX and RX, then polls STATUS continuously. It moves bytes from a valid/ready TX stream into the peripheral DATA register and from the peripheral DATA register out to a valid/ready RX stream. It sits between client logic (a command parser or DMA) and the UART peripheral's bus port.

## Interface
- DATA_WIDTH, 8: byte width carried on the stream ports and in DATA[DATA_WIDTH-1:0].
- CTRL_INIT, 2'b11: value written to CTRL[1:0] after reset; bit0 is tx_en, bit1 is rx_en.
- POLL_GAP, 0: idle cycles inserted after each completed transaction before the next STATUS poll.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  when low, the FSM parks in IDLE after finishing the current transaction.
- stb_o  out  1  bus strobe; one-cycle pulse per transaction.
- adr_o  out  2  register address: 0 BAUD, 1 CTRL, 2 STATUS, 3 DATA.
- byte_sel_o  out  4  always 4'b0001 during writes, 4'b0000 otherwise.
- we_o  out  1  write enable, qualified by stb_o.
- data_o  out  32  write data, zero-extended.
- data_i  in  32  read data from the peripheral; valid the cycle after a read strobe.
- tx_valid_i / tx_data_i / tx_ready_o  in / in / out  1 / DATA_WIDTH / 1  TX byte stream.
- rx_valid_o / rx_data_o / rx_ready_i  out / out / in  1 / DATA_WIDTH / 1  RX byte stream.
- status_o  out  5  last polled STATUS[4:0]: {frame_err, rx_empty, rx_full, tx_empty, tx_full}.

## Operation
- States: CFG, IDLE, POLL_REQ, POLL_CAP, TX_WR, RX_REQ, RX_CAP, GAP.
- CFG: stb_o=1, we_o=1, adr_o=1, data_o={30'b0, CTRL_INIT}. Next state is POLL_REQ if en_i is high, otherwise IDLE.
- IDLE: no strobe. Goes to POLL_REQ when en_i is high.
- POLL_REQ: stb_o=1, we_o=0, adr_o=2. Next state is POLL_CAP.
- POLL_CAP: no strobe. status_o is registered from data_i[4:0].
  - TX is eligible when tx_valid_i is high and data_i[0]=0 (TX FIFO not full).
  - RX is eligible when data_i[3]=0 (RX FIFO not empty) and rx_valid_o=0.
  - If both are eligible, serve the direction not served last (round-robin flag; reset value favours TX).
  - If only one is eligible, go to TX_WR or RX_REQ accordingly.
  - If neither is eligible, go to GAP.
- TX_WR: stb_o=1, we_o=1, adr_o=3, data_o={24'b0, tx_data_i}, tx_ready_o=1. The handshake completes in this cycle. Next state is GAP.
- RX_REQ: stb_o=1, we_o=0, adr_o=3. Next state is RX_CAP.
- RX_CAP: rx_data_o is registered from data_i[DATA_WIDTH-1:0] and rx_valid_o is set. Next state is GAP.
- GAP: counts POLL_GAP cycles; with POLL_GAP=0 it is skipped, i.e. the predecessor state transitions straight to the GAP exit target. Exit target is POLL_REQ if en_i is high, otherwise IDLE.
- RX stream: rx_valid_o/rx_data_o hold until the cycle in which rx_ready_i=1, then rx_valid_o clears on the next edge. No new RX read is issued while rx_valid_o=1.
- TX stream: clients must hold tx_valid_i and tx_data_i stable until tx_ready_o. The block never writes DATA without a fresh STATUS poll showing tx_full=0, so no byte is silently dropped by the peripheral.
- The BAUD register is never accessed.

## Timing
- Reset values: stb_o=0, we_o=0, adr_o=0, byte_sel_o=0, data_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, status_o=0, state=CFG.
- All bus outputs are registered.
- CFG strobe appears in the first cycle after rst_i deasserts.
- With POLL_GAP=0, one poll loop is 2 cycles.
- TX latency: tx_ready_o is asserted 2 cycles after the POLL_REQ strobe.
- RX latency: rx_valid_o is asserted 4 cycles after the POLL_REQ strobe.
- Read data is sampled exactly one cycle after the read strobe.
- rst_i asserted mid-transaction:
  - Next edge returns to CFG.
  - Pending RX byte is discarded and rx_valid_o clears.
  - Any handshake not yet completed is abandoned.
- en_i deasserted mid-transaction: the transaction completes, then the FSM parks in IDLE. status_o and rx_valid_o are preserved.
- Frame error: status_o[4] only reports the bit. It does not alter flow.

## Structure
- Shared package uart_pkg holds:
  - the register address enum (BAUD/CTRL/STATUS/DATA = 0..3);
  - STATUS bit index constants (TX_FULL=0, TX_EMPTY=1, RX_FULL=2, RX_EMPTY=3, FRAME_ERR=4);
  - CTRL bit indices (TX_EN=0, RX_EN=1);
  - the uart_host state enum.
- Single module. No sub-module is warranted; the POLL_GAP counter is inline.

## Test plan
- Reset release → CFG write with adr_o=1, data_o=32'h3, byte_sel_o=4'b0001 in cycle 1, then a STATUS read strobe in cycle 2.
- tx_valid_i=1, tx_data_i=8'hA5, peripheral status 5'b01010 → write to adr 3 with data_o=32'hA5, tx_ready_o pulsed for 1 cycle.
- Status tx_full=1 with tx_valid_i held → no DATA write and tx_ready_o stays 0 across 10 polls. Clearing full → exactly one write.
- Status rx_empty=0, DATA read returns 32'h3C → rx_valid_o=1, rx_data_o=8'h3C, held while rx_ready_i=0. No further DATA read until rx_ready_i=1.
- Both TX and RX eligible every poll → DATA write and DATA read alternate, TX first after reset.
- rst_i during RX_REQ → next cycle stb_o=0, rx_valid_o=0, then CFG write. en_i=0 → FSM parks in IDLE with no strobes.
